spi_frame_ctrl: RTL

- Controller and scheduler for the 11-bit negedge serial frame deserializer. The deserializer exposes its frame word and its 6-bit frame counter.
- Runs in the system clock domain. Detects each new frame by watching the counter advance, and waits until the counter is stable before capturing the frame.
- Checks the PS/2-style framing: start bit, 8 data bits LSB first, odd parity, stop bit.
- Queues good bytes into a small FIFO with a valid/ready output, counts lost frames and errors, and drives an inhibit line that applies back-pressure to the serial source.

---
 rtl/spi_frame_ctrl.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/spi_frame_ctrl.sv
// rtl/spi_frame_ctrl.sv - frame capture, PS/2-style framing check and byte FIFO for the negedge deserializer
module spi_frame_ctrl #(
    parameter int STABLE_CYCLES = 4,
    parameter int FIFO_DEPTH    = 4,
    parameter int INIT_COUNT    = 63
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] frame,
    input  logic [5:0]  frame_count,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        inhibit,
    output logic        err_parity,
    output logic        err_framing,
    output logic        err_overrun,
    output logic [7:0]  lost_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CHECK, S_PUSH} state_t;

    state_t         r_state, w_state_n;
    logic [5:0]     r_sync1, r_sync2, r_cand, r_last;
    logic [5:0]     w_cand_n, w_last_n, w_delta;
    logic [SW-1:0]  r_stab, w_stab_n;
    logic [10:0]    r_frame_q, w_frame_q_n;
    logic           r_err_p, r_err_f, r_err_o;
    logic           w_err_p_n, w_err_f_n, w_err_o_n;
    logic [7:0]     r_lost, w_lost_inc, w_lost_n;
    logic [8:0]     w_lost_sum;
    logic           w_framing_bad, w_parity_bad, w_push, w_pop, w_full;

    logic [7:0]     r_mem [FIFO_DEPTH];
    logic [AW-1:0]  r_wr_ptr, r_rd_ptr, w_rd_n;
    logic [CW-1:0]  r_count, w_count_n;
    logic [7:0]     r_out_data, w_head_n;
    logic           r_inhibit;

    assign w_delta       = r_cand - r_last;
    assign w_framing_bad = r_frame_q[0] | ~r_frame_q[10];
    assign w_parity_bad  = ~(^r_frame_q[9:1]);
    assign w_full        = (r_count == CW'(FIFO_DEPTH));
    assign w_pop         = (r_count != '0) && out_ready;
    assign w_lost_sum    = {1'b0, r_lost} + {1'b0, w_lost_inc};
    assign w_lost_n      = w_lost_sum[8] ? 8'hFF : w_lost_sum[7:0];

    always_comb begin
        w_state_n   = r_state;
        w_cand_n    = r_cand;
        w_stab_n    = r_stab;
        w_frame_q_n = r_frame_q;
        w_last_n    = r_last;
        w_err_p_n   = 1'b0;
        w_err_f_n   = 1'b0;
        w_err_o_n   = 1'b0;
        w_lost_inc  = 8'd0;
        w_push      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_sync2 != r_last) begin
                    w_cand_n  = r_sync2;
                    w_stab_n  = '0;
                    w_state_n = S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_sync2 != r_cand) begin
                    w_cand_n = r_sync2;
                    w_stab_n = '0;
                end else if (r_stab == SW'(STABLE_CYCLES - 1)) begin
                    w_frame_q_n = frame;
                    w_state_n   = S_CHECK;
                end else begin
                    w_stab_n = r_stab + SW'(1);
                end
            end
            S_CHECK: begin
                if (w_delta > 6'd1) begin
                    w_err_o_n  = 1'b1;
                    w_lost_inc = {2'b00, w_delta - 6'd1};
                end
                w_last_n  = r_cand;
                w_err_f_n = w_framing_bad;
                w_err_p_n = w_parity_bad;
                w_state_n = (w_framing_bad || w_parity_bad) ? S_IDLE : S_PUSH;
            end
            S_PUSH: begin
                // A pop in the same cycle frees the slot the push needs
                if (!w_full || w_pop) begin
                    w_push = 1'b1;
                end else begin
                    w_err_o_n  = 1'b1;
                    w_lost_inc = 8'd1;
                end
                w_state_n = S_IDLE;
            end
            default: w_state_n = S_IDLE;
        endcase
    end

    always_comb begin
        w_count_n = r_count;
        if (w_push && !w_pop) begin
            w_count_n = r_count + CW'(1);
        end else if (!w_push && w_pop) begin
            w_count_n = r_count - CW'(1);
        end
        w_rd_n   = w_pop ? r_rd_ptr + AW'(1) : r_rd_ptr;
        w_head_n = (w_push && (r_wr_ptr == w_rd_n)) ? r_frame_q[8:1] : r_mem[w_rd_n];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_sync1    <= 6'(INIT_COUNT);
            r_sync2    <= 6'(INIT_COUNT);
            r_cand     <= 6'(INIT_COUNT);
            r_last     <= 6'(INIT_COUNT);
            r_stab     <= '0;
            r_frame_q  <= '0;
            r_err_p    <= 1'b0;
            r_err_f    <= 1'b0;
            r_err_o    <= 1'b0;
            r_lost     <= 8'd0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_out_data <= 8'd0;
            r_inhibit  <= 1'b0;
        end else begin
            r_state    <= w_state_n;
            r_sync1    <= frame_count;
            r_sync2    <= r_sync1;
            r_cand     <= w_cand_n;
            r_last     <= w_last_n;
            r_stab     <= w_stab_n;
            r_frame_q  <= w_frame_q_n;
            r_err_p    <= w_err_p_n;
            r_err_f    <= w_err_f_n;
            r_err_o    <= w_err_o_n;
            r_lost     <= w_lost_n;
            r_wr_ptr   <= w_push ? r_wr_ptr + AW'(1) : r_wr_ptr;
            r_rd_ptr   <= w_rd_n;
            r_count    <= w_count_n;
            r_out_data <= (w_count_n == '0) ? 8'd0 : w_head_n;
            r_inhibit  <= (w_count_n == CW'(FIFO_DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= r_frame_q[8:1];
        end
    end

    assign out_data    = r_out_data;
    assign out_valid   = (r_count != '0);
    assign inhibit     = r_inhibit;
    assign err_parity  = r_err_p;
    assign err_framing = r_err_f;
    assign err_overrun = r_err_o;
    assign lost_count  = r_lost;
endmodule
